// File: rtl/conv10_wb_pkg.sv
// Shared types and default geometry for the conv10 OFM write-back stage.
package conv10_wb_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHOUT = 512;
  localparam int unsigned DEF_WOUT  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } wb_state_e;

  // Address width: one layer's WOUT^2 * CHOUT words plus the layer-select MSB.
  function automatic int unsigned calc_aw(input int unsigned wout, input int unsigned chout);
    return $clog2(wout * wout * chout) + 1;
  endfunction

endpackage

// File: rtl/ofm_relu.sv
// Optional ReLU on one feature-map word: negative words clamp to zero.
module ofm_relu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  always_comb begin
    dout_o = din_i;
    if (en_i && din_i[WIDTH-1]) begin
      dout_o = '0;
    end
  end

endmodule

// File: rtl/conv10_ofm_writeback.sv
// Captures a parallel bank of conv10 OFM words and serialises them into the
// OFM RAM, one channel per cycle, with per-layer pixel counting and feedback.
module conv10_ofm_writeback
  import conv10_wb_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DSP_NO = DEF_CHOUT,
  parameter int unsigned CHOUT  = DEF_CHOUT,
  parameter int unsigned WOUT   = DEF_WOUT,
  parameter bit          RELU   = 1'b1,
  parameter int unsigned AW     = calc_aw(WOUT, CHOUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_i,
  input  logic             layer_sel_i,
  input  logic [WIDTH-1:0] ofm_i [0:DSP_NO-1],
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             ram_feedback_1,
  output logic             ram_feedback_2,
  output logic             overrun
);

  localparam int unsigned NPIX = WOUT * WOUT;
  localparam int unsigned PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned CW   = $clog2(CHOUT + 1);
  localparam int unsigned IW   = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int unsigned LW   = AW - 1;

  wb_state_e        state_q;
  logic [CW-1:0]    ch_q;
  logic             layer_q;
  logic [PW-1:0]    pix0_q;
  logic [PW-1:0]    pix1_q;
  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [WIDTH-1:0] wr_data_q;
  logic             busy_q;
  logic             fb1_q;
  logic             fb2_q;
  logic             overrun_q;
  logic [WIDTH-1:0] shadow_q [0:DSP_NO-1];

  logic             cur_layer_c;
  logic [PW-1:0]    pix_sel_c;
  logic [IW-1:0]    rd_idx_c;
  logic [WIDTH-1:0] mux_c;
  logic [WIDTH-1:0] relu_c;
  logic [LW-1:0]    base_c;
  logic             accept_c;

  // Channel 0 comes straight from the input bank so it can be written the
  // cycle after the sample; later channels come from the shadow buffer.
  assign accept_c    = (state_q == S_IDLE) && sample_i;
  assign cur_layer_c = (state_q == S_IDLE) ? layer_sel_i : layer_q;
  assign pix_sel_c   = cur_layer_c ? pix1_q : pix0_q;
  assign rd_idx_c    = IW'(ch_q);
  assign mux_c       = (state_q == S_IDLE) ? ofm_i[0] : shadow_q[rd_idx_c];
  assign base_c      = LW'(pix_sel_c) * LW'(CHOUT);

  ofm_relu #(
    .WIDTH (WIDTH)
  ) u_relu (
    .en_i   (RELU),
    .din_i  (mux_c),
    .dout_o (relu_c)
  );

  // Shadow buffer holds the accepted bank for the whole pixel; never reset.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      shadow_q <= ofm_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      layer_q   <= 1'b0;
      pix0_q    <= '0;
      pix1_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      fb1_q     <= 1'b0;
      fb2_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      fb1_q   <= 1'b0;
      fb2_q   <= 1'b0;
      if (sample_i && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (sample_i) begin
            layer_q   <= layer_sel_i;
            ch_q      <= CW'(1);
            wr_en_q   <= 1'b1;
            wr_addr_q <= {layer_sel_i, base_c};
            wr_data_q <= relu_c;
            busy_q    <= 1'b1;
            state_q   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (ch_q == CW'(CHOUT)) begin
            // Pixel complete: advance the latched layer's count, feedback on wrap.
            state_q <= S_DONE;
            if (layer_q) begin
              if (pix1_q == PW'(NPIX - 1)) begin
                pix1_q <= '0;
                fb2_q  <= 1'b1;
              end else begin
                pix1_q <= pix1_q + PW'(1);
              end
            end else begin
              if (pix0_q == PW'(NPIX - 1)) begin
                pix0_q <= '0;
                fb1_q  <= 1'b1;
              end else begin
                pix0_q <= pix0_q + PW'(1);
              end
            end
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= {layer_q, LW'(base_c + LW'(ch_q))};
            wr_data_q <= relu_c;
            ch_q      <= ch_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ch_q    <= '0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign busy           = busy_q;
  assign ram_feedback_1 = fb1_q;
  assign ram_feedback_2 = fb2_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_conv10_ofm_writeback.sv
// Self-checking bench: cycle-indexed write scoreboard plus table-driven probes
// and hand-written corner-case sequences; a RELU=0 twin shares the stimulus.
module tb_conv10_ofm_writeback;

  localparam int unsigned W    = 16;
  localparam int unsigned DSP  = 512;
  localparam int unsigned CH   = 512;
  localparam int unsigned WO   = 8;
  localparam int unsigned NPIX = WO * WO;
  localparam int unsigned AW   = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample_i;
  logic          layer_sel_i;
  logic [W-1:0]  ofm [0:DSP-1];
  logic          wr_en, nr_wr_en;
  logic [AW-1:0] wr_addr, nr_wr_addr;
  logic [W-1:0]  wr_data, nr_wr_data;
  logic          busy, nr_busy;
  logic          ram_feedback_1, nr_fb1;
  logic          ram_feedback_2, nr_fb2;
  logic          overrun, nr_overrun;

  always #5 clk = ~clk;

  conv10_ofm_writeback #(
    .WIDTH(W), .DSP_NO(DSP), .CHOUT(CH), .WOUT(WO), .RELU(1'b1), .AW(AW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .sample_i(sample_i), .layer_sel_i(layer_sel_i),
    .ofm_i(ofm), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .ram_feedback_1(ram_feedback_1), .ram_feedback_2(ram_feedback_2),
    .overrun(overrun)
  );

  conv10_ofm_writeback #(
    .WIDTH(W), .DSP_NO(DSP), .CHOUT(CH), .WOUT(WO), .RELU(1'b0), .AW(AW)
  ) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .sample_i(sample_i), .layer_sel_i(layer_sel_i),
    .ofm_i(ofm), .wr_en(nr_wr_en), .wr_addr(nr_wr_addr), .wr_data(nr_wr_data),
    .busy(nr_busy), .ram_feedback_1(nr_fb1), .ram_feedback_2(nr_fb2),
    .overrun(nr_overrun)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endfunction

  // Reference model: every accepted sample schedules CH writes by absolute cycle.
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [W-1:0]  d_relu;
    logic [W-1:0]  d_raw;
  } wr_t;

  wr_t  exp_q[$];
  int   cyc = 0;
  int   busy_end = -1;
  int   fb_cyc [2] = '{-1, -1};
  int   pix [2] = '{0, 0};
  bit   m_ovr = 1'b0;
  int   n_wr = 0;
  int   n_fb1 = 0;
  int   n_fb2 = 0;

  function automatic logic [W-1:0] relu_ref(input logic [W-1:0] w);
    return ($signed(w) < 0) ? '0 : w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic          e_wr;
    logic [63:0]   a, e;
    wr_t           item;
    if (cyc > 0) begin
      e_wr = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
      a = {wr_en, wr_en ? wr_addr : 16'h0, wr_en ? wr_data : 16'h0,
           busy, ram_feedback_1, ram_feedback_2, overrun,
           nr_wr_en, nr_wr_en ? nr_wr_data : 16'h0};
      e = {e_wr, e_wr ? exp_q[0].addr : 16'h0, e_wr ? exp_q[0].d_relu : 16'h0,
           (cyc <= busy_end), (fb_cyc[0] == cyc), (fb_cyc[1] == cyc), m_ovr,
           e_wr, e_wr ? exp_q[0].d_raw : 16'h0};
      check("cycle", a, e);
      if (e_wr) void'(exp_q.pop_front());
      if (wr_en) n_wr++;
      if (ram_feedback_1) n_fb1++;
      if (ram_feedback_2) n_fb2++;
    end
    if (!rst_n) begin
      exp_q.delete();
      busy_end = -1;
      fb_cyc   = '{-1, -1};
      pix      = '{0, 0};
      m_ovr    = 1'b0;
    end else if (sample_i) begin
      if (cyc <= busy_end) begin
        m_ovr = 1'b1;
      end else begin
        for (int k = 0; k < CH; k++) begin
          item.cyc    = cyc + 1 + k;
          item.addr   = AW'(int'(layer_sel_i) * 32768 + pix[layer_sel_i] * CH + k);
          item.d_relu = relu_ref(ofm[k]);
          item.d_raw  = ofm[k];
          exp_q.push_back(item);
        end
        busy_end = cyc + CH + 1;
        pix[layer_sel_i]++;
        if (pix[layer_sel_i] == NPIX) begin
          pix[layer_sel_i] = 0;
          fb_cyc[layer_sel_i] = cyc + CH + 1;
        end
      end
    end
  end

  task automatic scramble();
    for (int k = 0; k < DSP; k++) ofm[k] = W'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // Sample pulse for one cycle; returns in the cycle that shows channel 0.
  task automatic send(input logic lay);
    @(posedge clk); #1 sample_i = 1'b1; layer_sel_i = lay;
    @(posedge clk); #1 sample_i = 1'b0; scramble();
  endtask

  typedef struct {
    logic          layer;
    int            ch;
    logic [W-1:0]  word;
    logic [AW-1:0] exp_addr;
    logic [W-1:0]  exp_relu;
    logic [W-1:0]  exp_raw;
  } probe_t;

  probe_t tbl [6];
  logic   seq [128];

  initial begin
    int first, cnt, last_busy, bad, last_addr, wr0, n0, n1, fb1_0, fb2_0;
    logic lay, tmp;

    rst_n = 1'b0; sample_i = 1'b0; layer_sel_i = 1'b0;
    for (int k = 0; k < DSP; k++) ofm[k] = '0;

    tbl[0] = '{1'b0,   0, 16'h1234, 16'h0000, 16'h1234, 16'h1234};
    tbl[1] = '{1'b0, 511, 16'hFFFF, 16'h03FF, 16'h0000, 16'hFFFF};
    tbl[2] = '{1'b1,   7, 16'h8001, 16'h8007, 16'h0000, 16'h8001};
    tbl[3] = '{1'b1, 300, 16'h7FFF, 16'h832C, 16'h7FFF, 16'h7FFF};
    tbl[4] = '{1'b0, 255, 16'h8000, 16'h04FF, 16'h0000, 16'h8000};
    tbl[5] = '{1'b0, 256, 16'h0000, 16'h0700, 16'h0000, 16'h0000};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_state",
          {wr_en, wr_addr, wr_data, busy, ram_feedback_1, ram_feedback_2, overrun},
          64'h0);

    // Probes: one marked word per pixel, checked at its channel's write cycle.
    for (int i = 0; i < 6; i++) begin
      scramble();
      ofm[tbl[i].ch] = tbl[i].word;
      send(tbl[i].layer);
      repeat (tbl[i].ch) @(posedge clk);
      @(negedge clk);
      check($sformatf("probe%0d", i), {wr_en, wr_addr, wr_data, nr_wr_data},
            {1'b1, tbl[i].exp_addr, tbl[i].exp_relu, tbl[i].exp_raw});
      repeat (CH + 2 - tbl[i].ch) @(posedge clk);
    end

    // Single ramp pixel: window and busy timing relative to the pulse.
    do_reset();
    for (int k = 0; k < DSP; k++) ofm[k] = W'(k - 256);
    send(1'b0);
    first = -1; cnt = 0; last_busy = -1; bad = 0; last_addr = -1;
    for (int i = 1; i <= CH + 4; i++) begin
      @(negedge clk);
      if (wr_en) begin
        if (first < 0) first = i;
        if (wr_addr !== AW'(i - 1)) bad++;
        if (wr_data !== ((i - 1 < 256) ? W'(0) : W'(i - 1 - 256))) bad++;
        last_addr = int'(wr_addr);
        cnt++;
      end
      if (busy) last_busy = i;
      @(posedge clk);
    end
    check("t1_first", 64'(first), 64'd1);
    check("t1_count", 64'(cnt), 64'(CH));
    check("t1_busy_last", 64'(last_busy), 64'(CH + 1));
    check("t1_last_addr", 64'(last_addr), 64'(CH - 1));
    check("t1_data_bad", 64'(bad), 64'd0);

    // Second sample 100 cycles into a pixel: ignored, overrun sticks.
    do_reset();
    scramble();
    wr0 = n_wr;
    send(1'b0);
    repeat (98) @(posedge clk);
    @(posedge clk); #1 sample_i = 1'b1; layer_sel_i = 1'b1; scramble();
    @(negedge clk);
    check("ovr_before", 64'(overrun), 64'd0);
    @(posedge clk); #1 sample_i = 1'b0;
    @(negedge clk);
    check("ovr_rise", 64'(overrun), 64'd1);
    repeat (CH + 10) @(posedge clk);
    @(negedge clk);
    check("ovr_sticky", {overrun, busy}, 64'b10);
    check("ovr_writes", 64'(n_wr - wr0), 64'(CH));

    // Reset at channel 300 of the second layer-0 pixel abandons it.
    do_reset();
    scramble();
    send(1'b0);
    repeat (CH) @(posedge clk);
    scramble();
    send(1'b0);
    repeat (300) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_addr", {wr_en, wr_addr}, {1'b1, 16'd812});
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_off", {wr_en, busy}, 64'b00);
    scramble();
    ofm[0] = 16'h0042;
    send(1'b0);
    @(negedge clk);
    check("rst_restart", {wr_en, wr_addr, wr_data}, {1'b1, 16'h0000, 16'h0042});
    repeat (CH + 2) @(posedge clk);

    // Randomly interleaved layers, 64 pixels each, random legal spacing.
    for (int i = 0; i < 128; i++) seq[i] = (i >= 64);
    for (int i = 127; i > 0; i--) begin
      int j;
      j = $urandom_range(i, 0);
      tmp = seq[i]; seq[i] = seq[j]; seq[j] = tmp;
    end
    do_reset();
    fb1_0 = n_fb1; fb2_0 = n_fb2; n0 = 0; n1 = 0;
    for (int s = 0; s < 128; s++) begin
      lay = seq[s];
      if (lay) n1++; else n0++;
      scramble();
      send(lay);
      if (lay && n1 == 6) begin
        @(negedge clk);
        check("l1_pix5_base", {wr_en, wr_addr}, {1'b1, 16'h8A00});
      end
      if ((lay ? n1 : n0) == 64) begin
        repeat (CH - 1) @(posedge clk);
        @(negedge clk);
        check("last_addr", {wr_en, wr_addr}, {1'b1, lay ? 16'hFFFF : 16'h7FFF});
        @(posedge clk);
        @(negedge clk);
        check("fb_pulse", {ram_feedback_2, ram_feedback_1}, lay ? 64'b10 : 64'b01);
        repeat ($urandom_range(12, 0)) @(posedge clk);
      end else begin
        repeat (CH + $urandom_range(12, 0)) @(posedge clk);
      end
    end
    repeat (4) @(posedge clk);
    check("fb1_count", 64'(n_fb1 - fb1_0), 64'd1);
    check("fb2_count", 64'(n_fb2 - fb2_0), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
